// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx
//   Receive-side deserializer on the clk_8f bit-clock domain. Shifts the
//   registered serial stream in MSB-first and hunts for the comma symbol
//   COM_SYMBOL at any bit offset. After LOCK_COUNT consecutive byte-aligned
//   commas the link is declared active, and one aligned symbol is then
//   presented every 8 clocks with a single-cycle valid_out strobe. The comma
//   that completes lock is not output.
//
//   Parameters:
//     COM_SYMBOL  comma used for alignment (non-zero)
//     LOCK_COUNT  consecutive aligned commas needed to go active (>= 1)
//
//   Ports:
//     clk_8f     in   bit clock, all logic on the rising edge
//     reset      in   synchronous, active-high
//     data_in    in   serial bit, one per clk_8f, MSB first
//     data_out   out  [7:0] last aligned symbol
//     valid_out  out  one-cycle strobe, data_out holds a new symbol
//     active     out  high while locked (ACTIVE)
//
//   Build option:
//     RX_COM_STRIP_EN  when defined, boundary symbols equal to COM_SYMBOL are
//                      not strobed while active; data_out keeps its value.

module serial_paralelo_rx #(
    parameter logic [7:0] COM_SYMBOL = 8'hBC,
    parameter int         LOCK_COUNT = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    localparam int CW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [CW-1:0] LOCK_N = CW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [7:0]    sr;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [CW-1:0] com_cnt, com_cnt_n;
    logic [7:0]    data_out_n;
    logic          valid_n;
    logic [7:0]    w;
    logic          is_com;
    logic [CW-1:0] com_inc;

    // Candidate symbol for this edge: the seven stored bits plus the bit
    // being sampled now.
    assign w       = {sr[6:0], data_in};
    assign is_com  = (w == COM_SYMBOL);
    assign com_inc = com_cnt + CW'(1);
    assign active  = (state == ACTIVE);

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state     <= SEARCH;
            sr        <= '0;
            bit_cnt   <= '0;
            com_cnt   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            state     <= state_n;
            sr        <= w;
            bit_cnt   <= bit_cnt_n;
            com_cnt   <= com_cnt_n;
            data_out  <= data_out_n;
            valid_out <= valid_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        com_cnt_n  = com_cnt;
        data_out_n = data_out;
        valid_n    = 1'b0;

        unique case (state)
            SEARCH: begin
                if (is_com) begin
                    // The matching edge becomes bit position 7, so the next
                    // sampled bit starts a fresh symbol at bit_cnt 0.
                    bit_cnt_n = '0;
                    com_cnt_n = CW'(1);
                    state_n   = (LOCK_COUNT == 1) ? ACTIVE : ALIGN;
                end
            end

            ALIGN: begin
                bit_cnt_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (is_com) begin
                        com_cnt_n = com_inc;
                        if (com_inc == LOCK_N) begin
                            state_n = ACTIVE;
                        end
                    end else begin
                        // A broken run restarts the hunt from the next edge;
                        // this edge is deliberately not re-tested for a match.
                        com_cnt_n = '0;
                        state_n   = SEARCH;
                    end
                end
            end

            ACTIVE: begin
                bit_cnt_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
`ifdef RX_COM_STRIP_EN
                    if (!is_com) begin
                        data_out_n = w;
                        valid_n    = 1'b1;
                    end
`else
                    data_out_n = w;
                    valid_n    = 1'b1;
`endif
                end
            end

            default: begin
                state_n = SEARCH;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
module tb_serial_paralelo_rx;

    logic       clk;
    logic       rst0, din0, rst1, din1;
    logic [7:0] dout0, dout1;
    logic       val0, val1, act0, act1;

    int total = 0;
    int bad   = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    serial_paralelo_rx #(.COM_SYMBOL(8'hBC), .LOCK_COUNT(4)) dut (
        .clk_8f(clk), .reset(rst0), .data_in(din0),
        .data_out(dout0), .valid_out(val0), .active(act0)
    );

    serial_paralelo_rx #(.COM_SYMBOL(8'hBC), .LOCK_COUNT(1)) dut1 (
        .clk_8f(clk), .reset(rst1), .data_in(din1),
        .data_out(dout1), .valid_out(val1), .active(act1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop one expected symbol per strobe.
    always @(negedge clk) begin
        if (val0 === 1'b1) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL strobe0: got %02h expected no strobe", dout0);
            end else begin
                logic [7:0] e;
                e = q0.pop_front();
                if (dout0 !== e) begin
                    bad++;
                    $display("FAIL strobe0: got %02h expected %02h", dout0, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (val1 === 1'b1) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL strobe1: got %02h expected no strobe", dout1);
            end else begin
                logic [7:0] e;
                e = q1.pop_front();
                if (dout1 !== e) begin
                    bad++;
                    $display("FAIL strobe1: got %02h expected %02h", dout1, e);
                end
            end
        end
    end

    task automatic send_bit(input int which, input logic b);
        if (which == 0) din0 = b; else din1 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input int which, input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(which, v[i]);
    endtask

    task automatic send_byte(input int which, input logic [7:0] v);
        send_bits(which, v, 8);
    endtask

    task automatic do_reset(input int which, input int n);
        if (which == 0) begin rst0 = 1'b1; din0 = 1'b1; end
        else begin rst1 = 1'b1; din1 = 1'b1; end
        repeat (n) @(posedge clk);
        #1;
        if (which == 0) begin rst0 = 1'b0; din0 = 1'b0; end
        else begin rst1 = 1'b0; din1 = 1'b0; end
    endtask

    initial begin
        rst0 = 1'b1; din0 = 1'b0; rst1 = 1'b1; din1 = 1'b0;

        // Reset then lock
        do_reset(0, 2);
        check("rst_data", dout0, 8'h00);
        check("rst_valid", {7'd0, val0}, 8'd0);
        check("rst_active", {7'd0, act0}, 8'd0);
        q0.push_back(8'h5A);
        q0.push_back(8'h3C);
        repeat (3) send_byte(0, 8'hBC);
        send_bits(0, 8'hBC, 7);
        check("t1_active_bit31", {7'd0, act0}, 8'd0);
        send_bit(0, 1'b0);
        check("t1_active_bit32", {7'd0, act0}, 8'd1);
        check("t1_data_pre", dout0, 8'h00);
        send_byte(0, 8'h5A);
        send_byte(0, 8'h3C);

        // Arbitrary bit offset
        do_reset(0, 1);
        send_bit(0, 1'b1); send_bit(0, 1'b0); send_bit(0, 1'b1);
        q0.push_back(8'hA5);
        repeat (3) send_byte(0, 8'hBC);
        check("t2_active_pre", {7'd0, act0}, 8'd0);
        send_byte(0, 8'hBC);
        check("t2_active", {7'd0, act0}, 8'd1);
        send_byte(0, 8'hA5);
        check("t2_data", dout0, 8'hA5);

        // Broken lock
        do_reset(0, 1);
        q0.push_back(8'h77);
        send_byte(0, 8'hBC); send_byte(0, 8'hBC); send_byte(0, 8'h00);
        repeat (3) send_byte(0, 8'hBC);
        send_bits(0, 8'hBC, 7);
        check("t3_active_pre", {7'd0, act0}, 8'd0);
        send_bit(0, 1'b0);
        check("t3_active", {7'd0, act0}, 8'd1);
        send_byte(0, 8'h77);

        // Reset mid-operation, then relock
        do_reset(0, 1);
        q0.push_back(8'h99);
        repeat (4) send_byte(0, 8'hBC);
        send_byte(0, 8'h99);
        send_bits(0, 8'hF0, 3);
        do_reset(0, 1);
        check("t4_rst_data", dout0, 8'h00);
        check("t4_rst_valid", {7'd0, val0}, 8'd0);
        check("t4_rst_active", {7'd0, act0}, 8'd0);
        repeat (3) send_byte(0, 8'hBC);
        check("t4_relock_pre", {7'd0, act0}, 8'd0);
        send_byte(0, 8'hBC);
        check("t4_relock", {7'd0, act0}, 8'd1);
        q0.push_back(8'h42);
        send_byte(0, 8'h42);

        // Comma handling while active
        do_reset(0, 1);
        repeat (4) send_byte(0, 8'hBC);
        q0.push_back(8'h12);
`ifndef RX_COM_STRIP_EN
        q0.push_back(8'hBC);
`endif
        q0.push_back(8'h34);
        send_byte(0, 8'h12);
        send_byte(0, 8'hBC);
`ifdef RX_COM_STRIP_EN
        check("t6_com_data", dout0, 8'h12);
        check("t6_com_valid", {7'd0, val0}, 8'd0);
`else
        check("t6_com_data", dout0, 8'hBC);
        check("t6_com_valid", {7'd0, val0}, 8'd1);
`endif
        send_byte(0, 8'h34);
        check("t6_data", dout0, 8'h34);
        do_reset(0, 1);

        // LOCK_COUNT = 1 instance
        do_reset(1, 2);
        check("t5_rst_active", {7'd0, act1}, 8'd0);
        send_bits(1, 8'hBC, 7);
        check("t5_active_pre", {7'd0, act1}, 8'd0);
        send_bit(1, 1'b0);
        check("t5_active", {7'd0, act1}, 8'd1);
        q1.push_back(8'h11);
        send_bits(1, 8'h11, 7);
        check("t5_valid_pre", {7'd0, val1}, 8'd0);
        send_bit(1, 1'b1);
        check("t5_valid", {7'd0, val1}, 8'd1);
        check("t5_data", dout1, 8'h11);
        do_reset(1, 1);

        repeat (4) @(posedge clk);
        #1;
        check("q0_drained", 8'(q0.size()), 8'd0);
        check("q1_drained", 8'(q1.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_paralelo_rx.md
# serial_paralelo_rx

Receive-side deserializer that sits directly downstream of the receive input flop stage on the `clk_8f` domain. It shifts in the registered serial bit stream MSB-first and hunts for the comma symbol `COM_SYMBOL` at any bit position. Once `LOCK_COUNT` consecutive, byte-aligned commas have been seen, it declares the link active. From then on it emits one aligned 8-bit symbol with a one-cycle `valid_out` strobe every 8 clocks.

## Interface
Parameters:
- `COM_SYMBOL`, default `8'hBC`: comma used for alignment; must be non-zero.
- `LOCK_COUNT`, default `4`: consecutive aligned commas needed to enter ACTIVE; must be ≥1.

Ports:
- `clk_8f`, input, 1: bit clock; single clock, all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `data_in`, input, 1: serial bit from the upstream flop stage, one bit per `clk_8f`, MSB first.
- `data_out`, output, 8: last aligned symbol.
- `valid_out`, output, 1: one-cycle strobe; `data_out` holds a new symbol.
- `active`, output, 1: high while in ACTIVE.

## Operation
- Shift register `sr[7:0]` updates every non-reset cycle: `sr <= {sr[6:0], data_in}`.
- Window `w = {sr[6:0], data_in}` is combinational and is the candidate symbol on the current edge.
- `bit_cnt` is a 3-bit counter that wraps 7→0. `com_cnt` is wide enough to hold `LOCK_COUNT`.
- SEARCH (reset state):
  - Compare `w` on every edge.
  - On `w == COM_SYMBOL`: set `bit_cnt <= 0` and `com_cnt <= 1`.
  - Then go to ACTIVE if `LOCK_COUNT == 1`, else go to ALIGN.
- ALIGN:
  - `bit_cnt` increments every edge; `w` is checked only on edges where `bit_cnt == 7`.
  - Match: `com_cnt++`. If the new count equals `LOCK_COUNT`, go to ACTIVE.
  - Mismatch: go to SEARCH with `com_cnt <= 0`. The mismatching edge is not re-checked as a SEARCH match.
- ACTIVE:
  - `bit_cnt` keeps wrapping.
  - On each edge with `bit_cnt == 7`: `data_out <= w`, `valid_out <= 1`. On all other edges `valid_out <= 0`.
  - ACTIVE is left only by reset.
- The comma that completes lock is not output. The first `valid_out` carries the symbol after it.
- Reset contents of `sr` count as window bits. With `COM_SYMBOL` MSB set, a match needs at least 8 real bits.

## Timing
- Reset values: `data_out = 8'h00`, `valid_out = 0`, `active = 0`, state SEARCH, `sr = 0`, `bit_cnt = 0`, `com_cnt = 0`.
- Reset asserted on any edge overrides all activity, including mid-symbol and in ACTIVE. `data_in` is ignored on that edge.
- Latency: the last bit of a symbol is sampled on edge k. `data_out` and `valid_out` are visible after edge k, i.e. one cycle after that bit is presented.
- `valid_out` is high exactly 1 cycle in every 8 while ACTIVE. There are never two strobes within 8 cycles.
- `active` rises on the edge that samples the last bit of the `LOCK_COUNT`-th comma. It stays high until reset.
- If a comma match in SEARCH and a reset fall on the same edge, reset wins.

## Configuration
- Macro `RX_COM_STRIP_EN`.
- Defined: in ACTIVE, a boundary symbol equal to `COM_SYMBOL` does not assert `valid_out`. `data_out` keeps its previous value, and `bit_cnt` alignment is unaffected.
- Undefined: every boundary symbol in ACTIVE is output, commas included.

## Test plan
- Reset then lock: reset for 2 cycles, then send `BC BC BC BC 5A 3C` → `active` rises on the 32nd bit edge. `valid_out` pulses after bit 40 with `data_out = 8'h5A` and after bit 48 with `8'h3C`. `data_out = 0` before that.
- Arbitrary bit offset: send 3 junk bits `101`, then `BC ×4` and `A5` → lock and `data_out = 8'hA5` on the correct aligned boundary.
- Broken lock: send `BC BC 00 BC BC BC BC 77` → return to SEARCH after the `00`. `active` rises only after the last four `BC`, then `data_out = 8'h77`.
- Reset mid-operation: in ACTIVE, assert reset on bit 3 of a symbol → all outputs 0 on the next edge. Relock is required with 4 more `BC`.
- `LOCK_COUNT=1`: a single `BC` then `11` → `active` rises after 8 bits and `data_out = 8'h11` 8 cycles later.
- Macro: ACTIVE stream `12 BC 34`. With `RX_COM_STRIP_EN` defined: strobes only for `12` and `34`, and `data_out` stays `12` during the `BC` slot. Without it: three strobes.
